// File: rtl/sap_u.sv
// SAP-U 8-bit computer datapath: A/B registers, add/subtract ALU, 16xDW RAM with MAR, shared bus.
// Optional latched carry/zero flags are built when SAP_U_FLAGS_EN is defined.
module sap_u #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_a_load_n,
    input  logic                  reg_a_bus_enable_n,
    input  logic                  reg_b_load_n,
    input  logic                  reg_b_bus_enable_n,
    input  logic                  alu_enable_n,
    input  logic                  alu_subtract,
    input  logic [DATA_WIDTH-1:0] ram_dipswitch_data,
    input  logic [ADDR_WIDTH-1:0] ram_dipswitch_addr,
    input  logic                  ram_addr_select,
    input  logic                  ram_prog_mode,
    input  logic                  ram_output_enable_n,
    input  logic                  ram_control_signal,
    input  logic                  ram_load_mar_reg,
    input  logic                  ram_clear_mar_reg,
    input  logic [DATA_WIDTH-1:0] data_bus_in,
    output logic [DATA_WIDTH-1:0] bus_out,
    output logic [DATA_WIDTH-1:0] reg_a_out,
    output logic [DATA_WIDTH-1:0] reg_b_out,
    output logic [ADDR_WIDTH-1:0] mar_out,
    output logic                  alu_carry,
    output logic                  bus_conflict,
    output logic                  flag_carry,
    output logic                  flag_zero
);

    localparam int unsigned DW    = DATA_WIDTH;
    localparam int unsigned AW    = ADDR_WIDTH;
    localparam int unsigned SW    = DW + 1;
    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] r_reg_a;
    logic [DW-1:0] r_reg_b;
    logic [AW-1:0] r_mar;
    logic [DW-1:0] r_ram [DEPTH];

    logic [DW-1:0] w_bus;
    logic [DW-1:0] w_alu_operand_b;
    logic [SW-1:0] w_alu_sum;
    logic [DW-1:0] w_alu_result;
    logic [AW-1:0] w_ram_addr;
    logic [DW-1:0] w_ram_rdata;
    logic [DW-1:0] w_ram_wdata;
    logic [2:0]    w_drv_count;

    // Subtract is A + ~B + 1, so carry-out doubles as "no borrow" (A >= B).
    assign w_alu_operand_b = alu_subtract ? ~r_reg_b : r_reg_b;
    assign w_alu_sum       = SW'(r_reg_a) + SW'(w_alu_operand_b) + SW'(alu_subtract);
    assign w_alu_result    = w_alu_sum[DW-1:0];
    assign alu_carry       = w_alu_sum[DW];

    assign w_ram_addr  = ram_addr_select ? ram_dipswitch_addr : r_mar;
    assign w_ram_rdata = r_ram[w_ram_addr];
    assign w_ram_wdata = ram_prog_mode ? w_bus : ram_dipswitch_data;

    // Fixed-priority bus resolution; the external bus is the fallback driver.
    always_comb begin
        w_bus = data_bus_in;
        if (!alu_enable_n) begin
            w_bus = w_alu_result;
        end else if (!reg_a_bus_enable_n) begin
            w_bus = r_reg_a;
        end else if (!reg_b_bus_enable_n) begin
            w_bus = r_reg_b;
        end else if (!ram_output_enable_n) begin
            w_bus = w_ram_rdata;
        end
    end

    assign w_drv_count = 3'(!alu_enable_n) + 3'(!reg_a_bus_enable_n)
                       + 3'(!reg_b_bus_enable_n) + 3'(!ram_output_enable_n);
    assign bus_conflict = (w_drv_count > 3'd1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_reg_a <= '0;
        end else if (!reg_a_load_n) begin
            r_reg_a <= w_bus;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_reg_b <= '0;
        end else if (!reg_b_load_n) begin
            r_reg_b <= w_bus;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mar <= '0;
        end else if (ram_clear_mar_reg) begin
            r_mar <= '0;
        end else if (ram_load_mar_reg) begin
            r_mar <= w_bus[AW-1:0];
        end
    end

    // RAM writes are deliberately not gated by reset so the front panel can program during reset.
    always_ff @(posedge clk) begin
        if (ram_control_signal) begin
            r_ram[w_ram_addr] <= w_ram_wdata;
        end
    end

`ifdef SAP_U_FLAGS_EN
    logic r_flag_carry;
    logic r_flag_zero;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_flag_carry <= 1'b0;
            r_flag_zero  <= 1'b0;
        end else if (!alu_enable_n) begin
            r_flag_carry <= alu_carry;
            r_flag_zero  <= (w_alu_result == '0);
        end
    end

    assign flag_carry = r_flag_carry;
    assign flag_zero  = r_flag_zero;
`else
    assign flag_carry = 1'b0;
    assign flag_zero  = 1'b0;
`endif

    assign bus_out   = w_bus;
    assign reg_a_out = r_reg_a;
    assign reg_b_out = r_reg_b;
    assign mar_out   = r_mar;

endmodule

// File: tb/tb_sap_u.sv
// Directed self-checking bench for sap_u; flag expectations follow SAP_U_FLAGS_EN.
module tb_sap_u;

`ifdef SAP_U_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       reg_a_load_n, reg_a_bus_enable_n, reg_b_load_n, reg_b_bus_enable_n;
    logic       alu_enable_n, alu_subtract;
    logic [7:0] ram_dipswitch_data;
    logic [3:0] ram_dipswitch_addr;
    logic       ram_addr_select, ram_prog_mode, ram_output_enable_n, ram_control_signal;
    logic       ram_load_mar_reg, ram_clear_mar_reg;
    logic [7:0] data_bus_in;
    logic [7:0] bus_out, reg_a_out, reg_b_out;
    logic [3:0] mar_out;
    logic       alu_carry, bus_conflict, flag_carry, flag_zero;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sap_u dut (
        .clk(clk), .reset(reset),
        .reg_a_load_n(reg_a_load_n), .reg_a_bus_enable_n(reg_a_bus_enable_n),
        .reg_b_load_n(reg_b_load_n), .reg_b_bus_enable_n(reg_b_bus_enable_n),
        .alu_enable_n(alu_enable_n), .alu_subtract(alu_subtract),
        .ram_dipswitch_data(ram_dipswitch_data), .ram_dipswitch_addr(ram_dipswitch_addr),
        .ram_addr_select(ram_addr_select), .ram_prog_mode(ram_prog_mode),
        .ram_output_enable_n(ram_output_enable_n), .ram_control_signal(ram_control_signal),
        .ram_load_mar_reg(ram_load_mar_reg), .ram_clear_mar_reg(ram_clear_mar_reg),
        .data_bus_in(data_bus_in), .bus_out(bus_out),
        .reg_a_out(reg_a_out), .reg_b_out(reg_b_out), .mar_out(mar_out),
        .alu_carry(alu_carry), .bus_conflict(bus_conflict),
        .flag_carry(flag_carry), .flag_zero(flag_zero)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b1;
        reg_a_load_n = 1'b1; reg_a_bus_enable_n = 1'b1;
        reg_b_load_n = 1'b1; reg_b_bus_enable_n = 1'b1;
        alu_enable_n = 1'b1; alu_subtract = 1'b0;
        ram_addr_select = 1'b0; ram_prog_mode = 1'b0;
        ram_output_enable_n = 1'b1; ram_control_signal = 1'b0;
        ram_load_mar_reg = 1'b0; ram_clear_mar_reg = 1'b0;
    endtask

    task automatic load_a(input logic [7:0] v);
        data_bus_in = v; reg_a_load_n = 1'b0; tick(); reg_a_load_n = 1'b1;
    endtask

    task automatic load_b(input logic [7:0] v);
        data_bus_in = v; reg_b_load_n = 1'b0; tick(); reg_b_load_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        ram_dipswitch_data = 8'h00; ram_dipswitch_addr = 4'h0;
        data_bus_in = 8'h5A;
        reset = 1'b0;
        reg_a_load_n = 1'b0; reg_b_load_n = 1'b0; ram_load_mar_reg = 1'b1;
        tick();
        idle();
        n_checks++; if (reg_a_out !== 8'h00) begin n_fail++; $display("FAIL reset_a got %h exp 00", reg_a_out); end
        n_checks++; if (reg_b_out !== 8'h00) begin n_fail++; $display("FAIL reset_b got %h exp 00", reg_b_out); end
        n_checks++; if (mar_out !== 4'h0) begin n_fail++; $display("FAIL reset_mar got %h exp 0", mar_out); end
        n_checks++; if (bus_out !== 8'h5A) begin n_fail++; $display("FAIL reset_bus got %h exp 5a", bus_out); end
        n_checks++; if (bus_conflict !== 1'b0) begin n_fail++; $display("FAIL reset_conflict got %b exp 0", bus_conflict); end
        n_checks++; if ({flag_carry, flag_zero} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b exp 00", {flag_carry, flag_zero}); end
    endtask

    task automatic test_alu();
        load_a(8'h05);
        load_b(8'h03);
        data_bus_in = 8'hEE;
        alu_enable_n = 1'b0; alu_subtract = 1'b0; #1;
        n_checks++; if (bus_out !== 8'h08) begin n_fail++; $display("FAIL alu_add_bus got %h exp 08", bus_out); end
        n_checks++; if (alu_carry !== 1'b0) begin n_fail++; $display("FAIL alu_add_carry got %b exp 0", alu_carry); end
        alu_subtract = 1'b1; #1;
        n_checks++; if (bus_out !== 8'h02) begin n_fail++; $display("FAIL alu_sub_bus got %h exp 02", bus_out); end
        n_checks++; if (alu_carry !== 1'b1) begin n_fail++; $display("FAIL alu_sub_carry got %b exp 1", alu_carry); end
        // A <= A + B using pre-edge values
        alu_subtract = 1'b0; reg_a_load_n = 1'b0;
        tick();
        reg_a_load_n = 1'b1; alu_enable_n = 1'b1;
        n_checks++; if (reg_a_out !== 8'h08) begin n_fail++; $display("FAIL alu_accum got %h exp 08", reg_a_out); end
        n_checks++; if (reg_b_out !== 8'h03) begin n_fail++; $display("FAIL alu_b_hold got %h exp 03", reg_b_out); end
    endtask

    task automatic test_wrap();
        load_a(8'hFF);
        load_b(8'h01);
        alu_enable_n = 1'b0; alu_subtract = 1'b0; #1;
        n_checks++; if (bus_out !== 8'h00) begin n_fail++; $display("FAIL wrap_add_bus got %h exp 00", bus_out); end
        n_checks++; if (alu_carry !== 1'b1) begin n_fail++; $display("FAIL wrap_add_carry got %b exp 1", alu_carry); end
        tick();
        n_checks++; if (flag_zero !== FLAGS) begin n_fail++; $display("FAIL wrap_flag_zero got %b exp %b", flag_zero, FLAGS); end
        n_checks++; if (flag_carry !== FLAGS) begin n_fail++; $display("FAIL wrap_flag_carry got %b exp %b", flag_carry, FLAGS); end
        alu_enable_n = 1'b1;
        load_a(8'h00);
        // flags must hold while the ALU is not on the bus
        n_checks++; if (flag_zero !== FLAGS) begin n_fail++; $display("FAIL flag_hold got %b exp %b", flag_zero, FLAGS); end
        alu_enable_n = 1'b0; alu_subtract = 1'b1; #1;
        n_checks++; if (bus_out !== 8'hFF) begin n_fail++; $display("FAIL wrap_sub_bus got %h exp ff", bus_out); end
        n_checks++; if (alu_carry !== 1'b0) begin n_fail++; $display("FAIL wrap_sub_carry got %b exp 0", alu_carry); end
        tick();
        n_checks++; if ({flag_carry, flag_zero} !== 2'b00) begin n_fail++; $display("FAIL wrap_sub_flags got %b exp 00", {flag_carry, flag_zero}); end
        alu_enable_n = 1'b1; alu_subtract = 1'b0;
    endtask

    task automatic test_ram();
        ram_addr_select = 1'b1; ram_dipswitch_addr = 4'h3; ram_prog_mode = 1'b0;
        ram_dipswitch_data = 8'h01; data_bus_in = 8'hAA;
        ram_control_signal = 1'b1;
        tick();
        ram_control_signal = 1'b0; ram_output_enable_n = 1'b0; #1;
        n_checks++; if (bus_out !== 8'h01) begin n_fail++; $display("FAIL ram_dip_read got %h exp 01", bus_out); end
        // read-during-write: old data until the edge
        ram_dipswitch_data = 8'h77; ram_control_signal = 1'b1; #1;
        n_checks++; if (bus_out !== 8'h01) begin n_fail++; $display("FAIL ram_rdw_old got %h exp 01", bus_out); end
        tick();
        ram_control_signal = 1'b0;
        n_checks++; if (bus_out !== 8'h77) begin n_fail++; $display("FAIL ram_rdw_new got %h exp 77", bus_out); end
        ram_output_enable_n = 1'b1;
        // prog mode: bus data written at the MAR address
        data_bus_in = 8'h05; ram_load_mar_reg = 1'b1; tick(); ram_load_mar_reg = 1'b0;
        ram_addr_select = 1'b0; ram_prog_mode = 1'b1; data_bus_in = 8'hC4;
        ram_control_signal = 1'b1; tick(); ram_control_signal = 1'b0; ram_prog_mode = 1'b0;
        data_bus_in = 8'h00; ram_output_enable_n = 1'b0; #1;
        n_checks++; if (bus_out !== 8'hC4) begin n_fail++; $display("FAIL ram_prog_mar got %h exp c4", bus_out); end
        ram_addr_select = 1'b1; ram_dipswitch_addr = 4'h5; #1;
        n_checks++; if (bus_out !== 8'hC4) begin n_fail++; $display("FAIL ram_prog_dip got %h exp c4", bus_out); end
        ram_dipswitch_addr = 4'h3; #1;
        n_checks++; if (bus_out !== 8'h77) begin n_fail++; $display("FAIL ram_addr3_keep got %h exp 77", bus_out); end
        ram_output_enable_n = 1'b1;
        // RAM writes still happen during reset
        ram_dipswitch_addr = 4'h7; ram_dipswitch_data = 8'h99;
        reset = 1'b0; ram_control_signal = 1'b1; tick();
        reset = 1'b1; ram_control_signal = 1'b0; ram_output_enable_n = 1'b0; #1;
        n_checks++; if (bus_out !== 8'h99) begin n_fail++; $display("FAIL ram_write_in_reset got %h exp 99", bus_out); end
        n_checks++; if (mar_out !== 4'h0) begin n_fail++; $display("FAIL ram_reset_mar got %h exp 0", mar_out); end
        idle();
    endtask

    task automatic test_mar();
        data_bus_in = 8'h3A; ram_load_mar_reg = 1'b1; tick();
        n_checks++; if (mar_out !== 4'hA) begin n_fail++; $display("FAIL mar_load got %h exp a", mar_out); end
        ram_load_mar_reg = 1'b0; data_bus_in = 8'h06; tick();
        n_checks++; if (mar_out !== 4'hA) begin n_fail++; $display("FAIL mar_hold got %h exp a", mar_out); end
        ram_load_mar_reg = 1'b1; ram_clear_mar_reg = 1'b1; tick();
        n_checks++; if (mar_out !== 4'h0) begin n_fail++; $display("FAIL mar_clear_prio got %h exp 0", mar_out); end
        idle();
    endtask

    task automatic test_contention();
        load_a(8'h10);
        load_b(8'h20);
        data_bus_in = 8'h00;
        alu_enable_n = 1'b0; reg_a_bus_enable_n = 1'b0; #1;
        n_checks++; if (bus_out !== 8'h30) begin n_fail++; $display("FAIL cont_alu_a_bus got %h exp 30", bus_out); end
        n_checks++; if (bus_conflict !== 1'b1) begin n_fail++; $display("FAIL cont_alu_a_flag got %b exp 1", bus_conflict); end
        alu_enable_n = 1'b1; reg_b_bus_enable_n = 1'b0; #1;
        n_checks++; if (bus_out !== 8'h10) begin n_fail++; $display("FAIL cont_a_b_bus got %h exp 10", bus_out); end
        reg_a_bus_enable_n = 1'b1; #1;
        n_checks++; if (bus_out !== 8'h20) begin n_fail++; $display("FAIL cont_b_only_bus got %h exp 20", bus_out); end
        n_checks++; if (bus_conflict !== 1'b0) begin n_fail++; $display("FAIL cont_b_only_flag got %b exp 0", bus_conflict); end
        ram_output_enable_n = 1'b0; #1;
        n_checks++; if (bus_out !== 8'h20) begin n_fail++; $display("FAIL cont_b_ram_bus got %h exp 20", bus_out); end
        n_checks++; if (bus_conflict !== 1'b1) begin n_fail++; $display("FAIL cont_b_ram_flag got %b exp 1", bus_conflict); end
        reg_b_bus_enable_n = 1'b1; ram_addr_select = 1'b1; ram_dipswitch_addr = 4'h5; #1;
        n_checks++; if (bus_out !== 8'hC4) begin n_fail++; $display("FAIL cont_ram_only_bus got %h exp c4", bus_out); end
        idle();
    endtask

    task automatic test_back_to_back();
        // swap-style transfer: A drives, both load in the same edge
        reg_a_bus_enable_n = 1'b0; reg_a_load_n = 1'b0; reg_b_load_n = 1'b0;
        tick();
        idle();
        n_checks++; if (reg_b_out !== 8'h10) begin n_fail++; $display("FAIL b2b_b_from_a got %h exp 10", reg_b_out); end
        n_checks++; if (reg_a_out !== 8'h10) begin n_fail++; $display("FAIL b2b_a_self got %h exp 10", reg_a_out); end
        // consecutive accumulations A <= A + B
        alu_enable_n = 1'b0; reg_a_load_n = 1'b0;
        tick(); tick(); tick();
        idle();
        n_checks++; if (reg_a_out !== 8'h40) begin n_fail++; $display("FAIL b2b_accum got %h exp 40", reg_a_out); end
    endtask

    initial begin
        idle();
        data_bus_in = 8'h00; ram_dipswitch_data = 8'h00; ram_dipswitch_addr = 4'h0;
        #2;
        test_reset();
        test_alu();
        test_wrap();
        test_ram();
        test_mar();
        test_contention();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
